divu_hilo: RTL and testbench
============================

# divu_hilo

Sequential unsigned divider that owns the HI/LO register pair of the ALU datapath. It sits directly upstream of the ALU output multiplexer. On a DIVU function code it divides `dataA` by `dataB` over 32 iterations and writes the remainder to HI and the quotient to LO. `HiOut`/`LoOut` are driven continuously so the multiplexer can return them on MFHI/MFLO.

## Interface

Parameters:
- `WIDTH`, 32: operand, quotient and remainder width.
- `DIVU_CODE`, 6'b011011: function code that starts a division.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `dataA`, input, WIDTH: dividend, sampled on the start edge only.
- `dataB`, input, WIDTH: divisor, sampled on the start edge only.
- `Signal`, input, 6: ALU function code.
- `HiOut`, output, WIDTH: HI register (remainder); feeds the output mux.
- `LoOut`, output, WIDTH: LO register (quotient); feeds the output mux.
- `busy`, output, 1: high while a division is in progress.
- `done`, output, 1: one-cycle pulse when HI/LO have just been written.

## Operation

- FSM states:
  - IDLE: no division in progress.
  - DIV: one restoring-division iteration per cycle; a 5-bit counter runs 0..31.
  - DONE: commits the result to HI/LO.
- Transitions:
  - IDLE → DIV when `Signal == DIVU_CODE`. On this edge the block latches `dataA` into the working quotient/dividend shift register, latches `dataB` into the divisor register, clears the partial remainder and clears the counter.
  - DIV → DIV while counter < 31. Each iteration shifts {rem, quo} left by 1 and trial-subtracts the divisor from the 33-bit {rem}. If the result is non-negative, rem ← difference and the quotient LSB ← 1; otherwise the quotient LSB ← 0.
  - DIV → DONE after the iteration with counter == 31.
  - DONE → IDLE unconditionally. On this edge HI ← remainder, LO ← quotient, and `done` goes high for exactly one cycle.
- Arithmetic is fully unsigned. The subtraction uses WIDTH+1 bits, so the borrow is the sign bit.
- Divide by zero is not trapped. The algorithm's natural result is required: LO = all ones, HI = dividend.
- A DIVU seen while in DIV or DONE is ignored: no restart, no queueing.
- All other `Signal` codes, including MFHI, MFLO and SLL, leave HI/LO unchanged. The block never writes HI/LO except from DONE.
- HI/LO hold their value indefinitely between divisions.
- Reset, including mid-division: state ← IDLE, HI = LO = 0, working registers cleared, `busy` = 0, `done` = 0. The interrupted operation is discarded.

## Timing

- Reset values: `HiOut` = 0, `LoOut` = 0, `busy` = 0, `done` = 0.
- Let E0 be the start edge:
  - E1..E32: the 32 iterations.
  - E32: enter DONE.
  - E33: HI/LO written and the FSM returns to IDLE.
- Latency: 33 clocks from start edge to HI/LO update.
- `busy` is registered: high from after E0 until E33, low after E33.
- `done` is high only during the cycle following E33.
- `HiOut`/`LoOut` change only at E33 (or on reset), never during iterations.
- If DIVU is held continuously, the next division starts at E34 with operands sampled at E34.
- MFHI issued in the cycle after E33 sees the new remainder through the mux.

## Structure

- Shared constants package `alu_pkg` holds the function codes AND, OR, ADD, SUB, SLT, SLL, DIVU, MFHI and MFLO. This block and the output mux both import them, so `DIVU_CODE` defaults from the package.
- State encoding (IDLE/DIV/DONE) is local to this block.
- One natural sub-module: `divu_step`, combinational. It takes {rem, quo, divisor} and returns the next {rem, quo} for one restoring iteration. The top holds the FSM, counter and HI/LO registers.

## Test plan

- Reset, then DIVU with A=100, B=7 → after 33 clocks, HiOut=2, LoOut=14; `done` pulses once; `busy` is high for exactly 33 cycles.
- A=0xFFFFFFFF, B=1 → LoOut=0xFFFFFFFF, HiOut=0. Then A=0x80000000, B=0x80000001 → LoOut=0, HiOut=0x80000000.
- A=5, B=0 → LoOut=0xFFFFFFFF, HiOut=5, with no hang.
- DIVU 100/7, then at cycle 10 pulse DIVU with A=9, B=3 → the second request is ignored; result stays HiOut=2, LoOut=14. MFHI/MFLO codes applied afterwards leave HI/LO unchanged.
- Start 100/7, assert reset low at cycle 10 → immediately HiOut=LoOut=0, busy=0. Release reset, run 50/6 → HiOut=2, LoOut=8 after 33 clocks.
- Hold DIVU high with A=20, B=3 → results HiOut=2, LoOut=6 at E33; the second division starts at E34 and its `done` pulses 33 clocks later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width and function codes.
// Imported by the HI/LO divider and by the ALU output multiplexer.
package alu_pkg;

    localparam int unsigned FUNC_W = 6;
    localparam int unsigned DATA_W = 32;

    typedef logic [FUNC_W-1:0] func_t;

    localparam func_t FN_SLL  = 6'b000000;
    localparam func_t FN_MFHI = 6'b010000;
    localparam func_t FN_MFLO = 6'b010010;
    localparam func_t FN_DIVU = 6'b011011;
    localparam func_t FN_ADD  = 6'b100000;
    localparam func_t FN_SUB  = 6'b100010;
    localparam func_t FN_AND  = 6'b100100;
    localparam func_t FN_OR   = 6'b100101;
    localparam func_t FN_SLT  = 6'b101010;

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration (combinational).
// Ports:
//   rem, quo, divisor   - current partial remainder, quotient/dividend shifter, divisor
//   rem_next_c          - partial remainder after this iteration
//   quo_next_c          - quotient/dividend shifter after this iteration
module divu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quo_next_c
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Shift {rem, quo} left by one and trial-subtract; the extra MSB is the borrow.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
        if (diff[WIDTH]) begin
            rem_next_c = rem_sh[WIDTH-1:0];
            quo_next_c = {quo[WIDTH-2:0], 1'b0};
        end else begin
            rem_next_c = diff[WIDTH-1:0];
            quo_next_c = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divu_hilo.sv
// Sequential unsigned divider owning the HI/LO register pair.
// A DIVU function code seen while idle starts a 32-iteration restoring
// division; the remainder lands in HI and the quotient in LO.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   dataA, dataB      - dividend / divisor, sampled on the start edge
//   Signal            - ALU function code
//   HiOut, LoOut      - HI (remainder) and LO (quotient) registers
//   busy              - division in progress
//   done              - one-cycle pulse after HI/LO are written
module divu_hilo
    import alu_pkg::*;
#(
    parameter int unsigned       WIDTH     = DATA_W,
    parameter logic [FUNC_W-1:0] DIVU_CODE = FN_DIVU
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  dataA,
    input  logic [WIDTH-1:0]  dataB,
    input  logic [FUNC_W-1:0] Signal,
    output logic [WIDTH-1:0]  HiOut,
    output logic [WIDTH-1:0]  LoOut,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  divisor;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem_step_c;
    logic [WIDTH-1:0]  quo_step_c;
    logic              load_c;
    logic              iter_c;
    logic              commit_c;

    divu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem        (rem),
        .quo        (quo),
        .divisor    (divisor),
        .rem_next_c (rem_step_c),
        .quo_next_c (quo_step_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; DIVU while busy is ignored
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Signal == DIVU_CODE) state_next = S_DIV;
            S_DIV:   if (cnt == CNT_LAST)     state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath controls decoded from the current state
    always_comb begin
        load_c   = 1'b0;
        iter_c   = 1'b0;
        commit_c = 1'b0;
        case (state)
            S_IDLE:  load_c   = (Signal == DIVU_CODE);
            S_DIV:   iter_c   = 1'b1;
            S_DONE:  commit_c = 1'b1;
            default: ;
        endcase
    end

    // Working registers: operand capture on start, one iteration per DIV cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            cnt     <= '0;
        end else if (load_c) begin
            rem     <= '0;
            quo     <= dataA;
            divisor <= dataB;
            cnt     <= '0;
        end else if (iter_c) begin
            rem     <= rem_step_c;
            quo     <= quo_step_c;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    // HI/LO only change on commit; status flags registered off next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HiOut <= '0;
            LoOut <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (commit_c) begin
                HiOut <= rem;
                LoOut <= quo;
            end
            busy <= (state_next != S_IDLE);
            done <= commit_c;
        end
    end

endmodule

// File: tb/tb_divu_hilo.sv
// Self-checking bench for divu_hilo: directed divisions, expected HI/LO
// results queued at issue time and popped by a monitor on each done pulse.
module tb_divu_hilo;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  dataA = '0;
    logic [W-1:0]  dataB = '0;
    logic [5:0]    Signal = FN_ADD;
    logic [W-1:0]  HiOut;
    logic [W-1:0]  LoOut;
    logic          busy;
    logic          done;

    int total     = 0;
    int passed    = 0;
    int done_seen = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    always #5 clk = ~clk;

    divu_hilo dut (
        .clk    (clk),
        .reset  (reset),
        .dataA  (dataA),
        .dataB  (dataB),
        .Signal (Signal),
        .HiOut  (HiOut),
        .LoOut  (LoOut),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued result
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no pending result", HiOut, LoOut);
            end else begin
                mon_exp = exp_q.pop_front();
                check("hi_result", HiOut, mon_exp[2*W-1:W]);
                check("lo_result", LoOut, mon_exp[W-1:0]);
            end
        end
    end

    // Called at a negedge: present DIVU for exactly one rising edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dataA  = a;
        dataB  = b;
        Signal = FN_DIVU;
        @(negedge clk);
        Signal = FN_ADD;
    endtask

    // Called at the negedge after some iteration edge: count busy cycles,
    // confirm HI/LO stay frozen until commit, then check the done pulse shape.
    task automatic wait_result(input string name, input int exp_busy);
        int            n      = 0;
        logic [W-1:0]  hi0    = HiOut;
        logic [W-1:0]  lo0    = LoOut;
        logic          stable = 1'b1;
        while (busy === 1'b1 && n < 100) begin
            if (HiOut !== hi0 || LoOut !== lo0) stable = 1'b0;
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            total++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, expected drop", name, n);
        end
        check({name, "_busy_cycles"}, W'(n), W'(exp_busy));
        check({name, "_hilo_frozen"}, W'(stable), W'(1));
        check({name, "_done_high"}, W'(done), W'(1));
        @(negedge clk);
        check({name, "_done_pulse_end"}, W'(done), W'(0));
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        #11;
        check("rst_hi",   HiOut, '0);
        check("rst_lo",   LoOut, '0);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic division
        exp_q.push_back({32'd2, 32'd14});
        issue(32'd100, 32'd7);
        wait_result("div_100_7", 33);

        // Boundary operands
        exp_q.push_back({32'h0, 32'hFFFF_FFFF});
        issue(32'hFFFF_FFFF, 32'd1);
        wait_result("div_max_1", 33);
        exp_q.push_back({32'h8000_0000, 32'h0});
        issue(32'h8000_0000, 32'h8000_0001);
        wait_result("div_big", 33);

        // Divide by zero: natural result, no hang
        exp_q.push_back({32'd5, 32'hFFFF_FFFF});
        issue(32'd5, 32'd0);
        wait_result("div_by_zero", 33);

        // DIVU during an active division is ignored
        exp_q.push_back({32'd2, 32'd14});
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dataA  = 32'd9;
        dataB  = 32'd3;
        Signal = FN_DIVU;
        @(negedge clk);
        Signal = FN_ADD;
        wait_result("div_ignore", 23);
        Signal = FN_MFHI;
        @(negedge clk);
        Signal = FN_MFLO;
        @(negedge clk);
        Signal = FN_SLL;
        @(negedge clk);
        Signal = FN_ADD;
        check("mf_hold_hi", HiOut, 32'd2);
        check("mf_hold_lo", LoOut, 32'd14);
        check("mf_hold_busy", W'(busy), W'(0));
        repeat (40) @(negedge clk);

        // Reset mid-division discards the operation
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_hi",   HiOut, '0);
        check("midrst_lo",   LoOut, '0);
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_still_zero", HiOut | LoOut, '0);
        exp_q.push_back({32'd2, 32'd8});
        issue(32'd50, 32'd6);
        wait_result("div_50_6", 33);

        // DIVU held: back-to-back divisions, restart at E34
        exp_q.push_back({32'd2, 32'd6});
        exp_q.push_back({32'd2, 32'd6});
        dataA  = 32'd20;
        dataB  = 32'd3;
        Signal = FN_DIVU;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
        check("hold_first_latency", W'(n), W'(34));
        check("hold_busy_gap", W'(busy), W'(0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
        Signal = FN_ADD;
        check("hold_second_gap", W'(n), W'(34));
        repeat (40) @(negedge clk);

        check("queue_drained", W'(exp_q.size()), W'(0));
        check("done_count", W'(done_seen), W'(8));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
